// File: rtl/vga_scan_controller.sv
// Purpose : 640x480@60 Hz VGA scan timing, pixel coordinates for the pixel ROMs,
//           and a registered color/sync output stage aligned one pixel period behind xpos/ypos.
// Latency : xpos/ypos lead the VGA pins by one pixel period (CLK_DIV clk); ROM color is sampled on pixel_tick.
// Backpressure: none, free-running; the scan never stalls.
//
// Ports:
//   clk, rst_n                   - system clock, asynchronous active-low reset
//   red_in/green_in/blue_in      - pixel ROM color for the current xpos/ypos (1 clk ROM latency)
//   xpos, ypos                   - scan counters, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   pixel_tick                   - one clk per pixel period (last clk of the period)
//   video_on                     - current xpos/ypos lies in the visible area
//   frame_end                    - one clk pulse on the last pixel of each frame
//   vga_hsync, vga_vsync         - registered active-low syncs
//   vga_red/vga_green/vga_blue   - registered, blanked color
module vga_scan_controller #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] red_in,
  input  logic [2:0] green_in,
  input  logic [1:0] blue_in,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       pixel_tick,
  output logic       video_on,
  output logic       frame_end,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [2:0] vga_red,
  output logic [2:0] vga_green,
  output logic [1:0] vga_blue
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS        = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  // State
  logic [DIV_W-1:0] div_q,   div_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [2:0]       red_q,   red_d;
  logic [2:0]       green_q, green_d;
  logic [1:0]       blue_q,  blue_d;

  // Decode of the current counter position
  logic tick;
  logic h_last;
  logic v_last;
  logic visible;
  logic hsync_active;
  logic vsync_active;

  always_comb begin
    tick         = (div_q == DIV_LAST);
    h_last       = (h_cnt_q == H_LAST);
    v_last       = (v_cnt_q == V_LAST);
    visible      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hsync_active = (h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END);
    vsync_active = (v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END);
  end

  // Divider and scan counters. The vertical counter only moves on the
  // tick that wraps the horizontal counter.
  always_comb begin
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // Output stage. Sampling on the last clk of the pixel period gives the
  // ROM CLK_DIV-1 clk to respond to the new xpos/ypos, and capturing the
  // syncs on the same edge keeps color and sync aligned at the pins.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (tick) begin
      hsync_d = ~hsync_active;
      vsync_d = ~vsync_active;
      red_d   = visible ? red_in   : 3'd0;
      green_d = visible ? green_in : 3'd0;
      blue_d  = visible ? blue_in  : 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      div_q   <= div_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign xpos       = h_cnt_q;
  assign ypos       = v_cnt_q;
  assign pixel_tick = tick;
  assign video_on   = visible;
  // Coincides with the tick that wraps both counters back to 0,0.
  assign frame_end  = tick && h_last && v_last;
  assign vga_hsync  = hsync_q;
  assign vga_vsync  = vsync_q;
  assign vga_red    = red_q;
  assign vga_green  = green_q;
  assign vga_blue   = blue_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller on a scaled-down raster so whole frames fit
// in a short run. Expected timing is derived from the number of clk edges
// since reset release; a monitor compares every pixel tick against it.
module tb_vga_scan_controller;

  localparam int CLK_DIV = 4;
  localparam int HD = 40, HF = 4, HS = 6, HB = 3;
  localparam int VD = 6,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;   // 53
  localparam int VT = VD + VF + VS + VB;   // 12
  localparam int FRAME_CLK = HT * VT * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] red_in = 3'b111;
  logic [2:0] green_in = 3'b111;
  logic [1:0] blue_in = 2'b11;
  logic [9:0] xpos, ypos;
  logic       pixel_tick, video_on, frame_end;
  logic       vga_hsync, vga_vsync;
  logic [2:0] vga_red, vga_green;
  logic [1:0] vga_blue;

  vga_scan_controller #(
    .CLK_DIV(CLK_DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .xpos(xpos), .ypos(ypos), .pixel_tick(pixel_tick), .video_on(video_on),
    .frame_end(frame_end), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pixel ROM model: one registered clk of latency. all_ones forces 8'hFF,
  // otherwise color = xpos[7:0] as {red, green, blue}.
  logic all_ones = 1'b1;
  always @(posedge clk) begin
    if (all_ones) {red_in, green_in, blue_in} <= 8'hFF;
    else          {red_in, green_in, blue_in} <= xpos[7:0];
  end

  typedef struct { int cyc; int x; int y; bit vis; bit fe; } pos_t;
  typedef struct { bit hs; bit vs; logic [7:0] rgb; } vga_t;

  pos_t pq[$];
  vga_t vq[$];
  int   cyc;

  // Producer: clk edges since release decide when each tick is due and what
  // the scan position and resulting VGA outputs must be.
  int  p_n, p_x, p_y;
  bit  p_vis;
  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      pq.delete();
      vq.delete();
      vq.push_back('{hs: 1'b1, vs: 1'b1, rgb: 8'h00});
    end else begin
      cyc++;
      if (cyc % CLK_DIV == CLK_DIV - 1) begin
        p_n   = (cyc - (CLK_DIV - 1)) / CLK_DIV;
        p_x   = p_n % HT;
        p_y   = (p_n / HT) % VT;
        p_vis = (p_x < HD) && (p_y < VD);
        pq.push_back('{cyc: cyc, x: p_x, y: p_y, vis: p_vis,
                       fe: (p_x == HT - 1) && (p_y == VT - 1)});
        vq.push_back('{hs: !((p_x >= HD + HF) && (p_x < HD + HF + HS)),
                       vs: !((p_y >= VD + VF) && (p_y < VD + VF + VS)),
                       rgb: p_vis ? (all_ones ? 8'hFF : 8'(p_x)) : 8'h00});
      end
    end
  end

  // Monitor: checks on the falling edge, away from the active edge.
  pos_t m_p;
  vga_t m_v;
  int   last_fe = -1;
  int   hs_run = 0;
  int   vs_run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_fe = -1;
      hs_run  = 0;
      vs_run  = 0;
    end else if (pixel_tick) begin
      if (pq.size() == 0 || vq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_tick: tick at cyc %0d, none expected", cyc);
      end else begin
        m_p = pq.pop_front();
        m_v = vq.pop_front();
        check("tick_cycle", cyc, m_p.cyc);
        check("xpos", xpos, m_p.x);
        check("ypos", ypos, m_p.y);
        check("video_on", video_on, m_p.vis);
        check("frame_end", frame_end, m_p.fe);
        check("vga_hsync", vga_hsync, m_v.hs);
        check("vga_vsync", vga_vsync, m_v.vs);
        check("vga_rgb", {vga_red, vga_green, vga_blue}, m_v.rgb);
      end
      // Pulse widths, counted in ticks as seen at the pins.
      if (!vga_hsync) hs_run++;
      else begin
        if (hs_run > 0) check("hsync_width", hs_run, HS);
        hs_run = 0;
      end
      if (!vga_vsync) vs_run++;
      else begin
        if (vs_run > 0) check("vsync_width", vs_run, VS * HT);
        vs_run = 0;
      end
      if (frame_end) begin
        if (last_fe >= 0) check("frame_period", cyc - last_fe, FRAME_CLK);
        last_fe = cyc;
      end
    end else begin
      check("frame_end_idle", frame_end, 0);
      if (vq.size() > 0) begin
        check("hold_hsync", vga_hsync, vq[0].hs);
        check("hold_vsync", vga_vsync, vq[0].vs);
        check("hold_rgb", {vga_red, vga_green, vga_blue}, vq[0].rgb);
      end
      if (pq.size() > 0 && pq[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL missed_tick: no tick at cyc %0d, expected one", pq[0].cyc);
        void'(pq.pop_front());
      end
    end
  end

  // Called at the falling edge where rst_n has just been released.
  task automatic startup_check();
    repeat (2) @(posedge clk);
    #1 check("tick_before_4th", pixel_tick, 0);
    @(posedge clk);
    #1 check("first_tick", pixel_tick, 1);
    check("first_tick_xpos", xpos, 0);
    @(posedge clk);
    #1 check("xpos_cycle5", xpos, 1);
    check("tick_cycle5", pixel_tick, 0);
  endtask

  bit found;

  initial begin
    // Reset with ROM returning all ones.
    rst_n = 1'b0;
    all_ones = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_xpos", xpos, 0);
    check("rst_ypos", ypos, 0);
    check("rst_hsync", vga_hsync, 1);
    check("rst_vsync", vga_vsync, 1);
    check("rst_rgb", {vga_red, vga_green, vga_blue}, 0);
    check("rst_tick", pixel_tick, 0);
    check("rst_frame_end", frame_end, 0);
    check("rst_video_on", video_on, 1);
    rst_n = 1'b1;
    startup_check();

    // Two frames of blanking with constant all-ones color.
    repeat (2 * FRAME_CLK + 40) @(posedge clk);

    // Find the second vsync line inside the hsync pulse.
    found = 1'b0;
    for (int i = 0; i < FRAME_CLK + 10; i++) begin
      @(posedge clk);
      #1;
      if (xpos == 10'(HD + HF + 3) && ypos == 10'(VD + VF + 1)) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_midframe", found, 1);
    check("pre_rst_hsync_low", vga_hsync, 0);
    check("pre_rst_vsync_low", vga_vsync, 0);
    rst_n = 1'b0;
    #1;
    check("async_xpos", xpos, 0);
    check("async_ypos", ypos, 0);
    check("async_hsync", vga_hsync, 1);
    check("async_vsync", vga_vsync, 1);
    check("async_tick", pixel_tick, 0);
    all_ones = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    startup_check();

    // One more frame with the xpos-colored ROM for alignment.
    repeat (FRAME_CLK + 40) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
